subframe_sequencer: RTL and testbench
=====================================

Name: subframe_sequencer

Overview:
Synthesizable successor to the testbench-modelled FSMIND0/FSMIND1 sensor handshake. It sequences a frame of N coded-exposure subframes. Per subframe it:
- requests the next pattern from DDR-backed pattern storage;
- performs the four-phase FSMIND1/FSMIND0 handshake with the imager;
- times the exposure;
- fires the projector trigger.

It sits between the FrontPanel wire/trigger registers (num_pat, exposure, proj trig) and the imager pins. It adds pattern count, trigger width, continuous mode and timeout detection.

Parameters:
- PAT_W, 8, width of pattern count/index.
- EXP_W, 32, width of exposure cycle counter.
- TRIG_W, 16, width of trigger delay.
- TRIG_PULSE, 4, projector trigger pulse width in clk cycles (>=1).
- TO_W, 24, width of handshake timeout counter.
- TIMEOUT, 1000000, cycles allowed in any handshake wait state.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin frame
- abort  in  1  level; cancel frame
- loop_en  in  1  1 = restart frame automatically after last subframe
- num_pat  in  PAT_W  subframes per frame
- exp_cycles  in  EXP_W  exposure length per subframe
- trig_delay  in  TRIG_W  cycles from exposure start to proj_trig rise
- pat_load  out  1  one-cycle request for pattern pat_idx
- pat_ready  in  1  pattern storage has delivered pattern
- pat_idx  out  PAT_W  current subframe index
- fsm_req  out  1  drives FSMIND1
- fsm_req_ack  in  1  FSMIND1ACK (asynchronous pin)
- fsm_done  in  1  FSMIND0 (asynchronous pin)
- fsm_done_ack  out  1  drives FSMIND0ACK
- proj_trig  out  1  projector trigger
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at frame end
- timeout_err  out  1  sticky handshake-timeout flag

Behaviour:
Reset:
- All outputs 0; state IDLE; pat_idx 0; timeout_err 0.

Input synchronisation and configuration:
- fsm_req_ack and fsm_done pass through 2-flop synchronisers (2-cycle latency). All decisions use the synchronised values.
- start in IDLE latches num_pat, exp_cycles (0 treated as 1) and trig_delay. It also clears timeout_err. Later changes to these inputs are ignored until the next frame.
- start with num_pat==0: no sequence; frame_done pulses the next cycle; stays IDLE.
- start while busy is ignored.

States:
- IDLE: wait for start.
- LOAD: pat_load=1 for the entry cycle only; wait for pat_ready. pat_ready in the entry cycle is accepted.
- REQ: fsm_req=1; wait for synchronised ack=1.
- EXPOSE:
  - fsm_req held 1; counter e runs 0..exp_cycles-1.
  - proj_trig=1 for cycles e in [trig_delay, trig_delay+TRIG_PULSE-1], truncated at exposure end.
  - If trig_delay>=exp_cycles, no trigger for that subframe.
- WAIT_DONE: fsm_req held 1; wait for synchronised done=1.
- DONE_ACK: fsm_req=0, fsm_done_ack=1; wait until synchronised done=0 and ack=0.
- NEXT (one cycle):
  - If pat_idx==num_pat_latched-1: pulse frame_done and set pat_idx=0. Then go to LOAD if loop_en=1 (sampled this cycle), else IDLE.
  - Otherwise pat_idx+1, go to LOAD.

Timeout:
- One counter, cleared on entry to LOAD, REQ, WAIT_DONE and DONE_ACK. It counts only in those states.
- Reaching TIMEOUT: timeout_err=1, all handshake outputs 0, go to IDLE, no frame_done.

Abort:
- abort=1 in any state forces IDLE next cycle.
- fsm_req, fsm_done_ack, proj_trig and pat_load go to 0 that same next cycle. pat_idx returns to 0. No frame_done.
- abort has priority over start and over timeout in the same cycle.

Simultaneous events:
- Simultaneous pat_ready and timeout in LOAD: pat_ready wins.

Reset mid-operation:
- rst_n low mid-frame immediately clears all outputs (asynchronous).

Test Plan:
- num_pat=3, exp=20, trig_delay=5, TRIG_PULSE=4, model asserts ack 10 cycles after fsm_req and done 20 cycles after ack, pat_ready 2 cycles after pat_load:
  - 3 pat_load pulses with pat_idx 0,1,2;
  - 3 proj_trig pulses each 4 cycles wide starting 5 cycles after EXPOSE entry;
  - a single frame_done;
  - busy falls after it.
- exp=3, trig_delay=1, TRIG_PULSE=4 -> proj_trig truncated to 2 cycles. trig_delay=3 -> no trigger; sequence still completes.
- TIMEOUT=100, model never asserts ack -> timeout_err=1 and fsm_req=0 exactly 100 cycles after REQ entry; no frame_done. The next start clears timeout_err.
- loop_en=1, num_pat=2 -> frame_done every 2 subframes with pat_idx wrapping 1->0. Asserting abort mid-EXPOSE -> IDLE in 1 cycle, all outputs 0, no frame_done.
- num_pat=0 start -> frame_done 1 cycle later, no fsm_req. Start while busy -> no effect.
- rst_n low during WAIT_DONE -> all outputs 0 asynchronously. After release, a normal frame completes.

Source files
------------

// File: rtl/subframe_sequencer.sv
// rtl/subframe_sequencer.sv - frame sequencer for coded-exposure subframes with FSMIND1/FSMIND0 imager handshake
module subframe_sequencer #(
   parameter int PAT_W      = 8,
   parameter int EXP_W      = 32,
   parameter int TRIG_W     = 16,
   parameter int TRIG_PULSE = 4,
   parameter int TO_W       = 24,
   parameter int TIMEOUT    = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              loop_en,
   input  logic [PAT_W-1:0]  num_pat,
   input  logic [EXP_W-1:0]  exp_cycles,
   input  logic [TRIG_W-1:0] trig_delay,
   output logic              pat_load,
   input  logic              pat_ready,
   output logic [PAT_W-1:0]  pat_idx,
   output logic              fsm_req,
   input  logic              fsm_req_ack,
   input  logic              fsm_done,
   output logic              fsm_done_ack,
   output logic              proj_trig,
   output logic              busy,
   output logic              frame_done,
   output logic              timeout_err
);

   typedef enum logic [2:0] {IDLE, LOAD, REQ, EXPOSE, WAIT_DONE, DONE_ACK, NEXT} state_t;

   localparam int CW = ((EXP_W > TRIG_W) ? EXP_W : TRIG_W) + 2;

   state_t            state;
   logic [1:0]        ack_sync;
   logic [1:0]        done_sync;
   logic              ack_s;
   logic              done_s;
   logic [PAT_W-1:0]  num_pat_q;
   logic [EXP_W-1:0]  exp_q;
   logic [EXP_W-1:0]  e_cnt;
   logic [TRIG_W-1:0] delay_q;
   logic [TO_W-1:0]   to_cnt;
   logic              to_hit;
   logic              hs_wait;
   logic              hs_go;
   logic [CW-1:0]     e_nxt_w;
   logic [CW-1:0]     win_lo;
   logic [CW-1:0]     win_hi;
   logic              trig_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync  <= 2'b00;
         done_sync <= 2'b00;
      end else begin
         ack_sync  <= {ack_sync[0], fsm_req_ack};
         done_sync <= {done_sync[0], fsm_done};
      end
   end

   assign ack_s  = ack_sync[1];
   assign done_s = done_sync[1];
   assign busy   = (state != IDLE);
   assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));

   // Trigger window is evaluated for the exposure count that will be current next cycle.
   assign e_nxt_w   = CW'(e_cnt) + CW'(1);
   assign win_lo    = CW'(delay_q);
   assign win_hi    = CW'(delay_q) + CW'(TRIG_PULSE);
   assign trig_next = (e_nxt_w >= win_lo) && (e_nxt_w < win_hi);

   always_comb begin
      hs_wait = 1'b0;
      hs_go   = 1'b0;
      case (state)
         LOAD:      begin hs_wait = 1'b1; hs_go = pat_ready;          end
         REQ:       begin hs_wait = 1'b1; hs_go = ack_s;              end
         WAIT_DONE: begin hs_wait = 1'b1; hs_go = done_s;             end
         DONE_ACK:  begin hs_wait = 1'b1; hs_go = !done_s && !ack_s;  end
         default:   begin hs_wait = 1'b0; hs_go = 1'b0;               end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         num_pat_q    <= '0;
         exp_q        <= '0;
         e_cnt        <= '0;
         delay_q      <= '0;
         to_cnt       <= '0;
         pat_idx      <= '0;
         pat_load     <= 1'b0;
         fsm_req      <= 1'b0;
         fsm_done_ack <= 1'b0;
         proj_trig    <= 1'b0;
         frame_done   <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         pat_load   <= 1'b0;
         frame_done <= 1'b0;
         if (abort) begin
            state        <= IDLE;
            fsm_req      <= 1'b0;
            fsm_done_ack <= 1'b0;
            proj_trig    <= 1'b0;
            pat_idx      <= '0;
         end else if (hs_wait && !hs_go && to_hit) begin
            state        <= IDLE;
            timeout_err  <= 1'b1;
            fsm_req      <= 1'b0;
            fsm_done_ack <= 1'b0;
            proj_trig    <= 1'b0;
            pat_idx      <= '0;
         end else begin
            if (hs_wait)
               to_cnt <= to_cnt + TO_W'(1);
            case (state)
               IDLE: begin
                  if (start) begin
                     num_pat_q   <= num_pat;
                     exp_q       <= (exp_cycles == '0) ? EXP_W'(1) : exp_cycles;
                     delay_q     <= trig_delay;
                     timeout_err <= 1'b0;
                     pat_idx     <= '0;
                     if (num_pat == '0) begin
                        frame_done <= 1'b1;
                     end else begin
                        state    <= LOAD;
                        pat_load <= 1'b1;
                        to_cnt   <= '0;
                     end
                  end
               end
               LOAD: begin
                  if (pat_ready) begin
                     state   <= REQ;
                     fsm_req <= 1'b1;
                     to_cnt  <= '0;
                  end
               end
               REQ: begin
                  if (ack_s) begin
                     state     <= EXPOSE;
                     e_cnt     <= '0;
                     proj_trig <= (delay_q == '0);
                  end
               end
               EXPOSE: begin
                  if (e_cnt == exp_q - EXP_W'(1)) begin
                     state     <= WAIT_DONE;
                     proj_trig <= 1'b0;
                     to_cnt    <= '0;
                  end else begin
                     e_cnt     <= e_cnt + EXP_W'(1);
                     proj_trig <= trig_next;
                  end
               end
               WAIT_DONE: begin
                  if (done_s) begin
                     state        <= DONE_ACK;
                     fsm_req      <= 1'b0;
                     fsm_done_ack <= 1'b1;
                     to_cnt       <= '0;
                  end
               end
               DONE_ACK: begin
                  if (!done_s && !ack_s) begin
                     state        <= NEXT;
                     fsm_done_ack <= 1'b0;
                  end
               end
               NEXT: begin
                  if (pat_idx == num_pat_q - PAT_W'(1)) begin
                     frame_done <= 1'b1;
                     pat_idx    <= '0;
                     if (loop_en) begin
                        state    <= LOAD;
                        pat_load <= 1'b1;
                        to_cnt   <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     pat_idx  <= pat_idx + PAT_W'(1);
                     state    <= LOAD;
                     pat_load <= 1'b1;
                     to_cnt   <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_subframe_sequencer.sv
// tb/tb_subframe_sequencer.sv - directed self-checking bench for subframe_sequencer
module tb_subframe_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        loop_en = 1'b0;
   logic [7:0]  num_pat = '0;
   logic [31:0] exp_cycles = '0;
   logic [15:0] trig_delay = '0;
   logic        pat_load;
   logic        pat_ready = 1'b0;
   logic [7:0]  pat_idx;
   logic        fsm_req;
   logic        fsm_req_ack = 1'b0;
   logic        fsm_done = 1'b0;
   logic        fsm_done_ack;
   logic        proj_trig;
   logic        busy;
   logic        frame_done;
   logic        timeout_err;

   subframe_sequencer #(
      .PAT_W(8), .EXP_W(32), .TRIG_W(16), .TRIG_PULSE(4), .TO_W(24), .TIMEOUT(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
      .num_pat(num_pat), .exp_cycles(exp_cycles), .trig_delay(trig_delay),
      .pat_load(pat_load), .pat_ready(pat_ready), .pat_idx(pat_idx),
      .fsm_req(fsm_req), .fsm_req_ack(fsm_req_ack), .fsm_done(fsm_done),
      .fsm_done_ack(fsm_done_ack), .proj_trig(proj_trig), .busy(busy),
      .frame_done(frame_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Imager and pattern-storage model, driven on the falling edge
   bit ack_en   = 1'b1;
   int done_dly = 20;
   int req_age  = 0;
   int done_age = 0;
   int pr_cnt   = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         fsm_req_ack = 1'b0; fsm_done = 1'b0; pat_ready = 1'b0;
         req_age = 0; done_age = 0; pr_cnt = 0;
      end else begin
         if (pr_cnt != 0) begin
            pr_cnt--;
            pat_ready = (pr_cnt == 0);
         end else begin
            pat_ready = 1'b0;
         end
         if (pat_load) pr_cnt = 2;
         if (!fsm_req) begin
            req_age = 0; fsm_req_ack = 1'b0;
         end else begin
            if (req_age < 10000) req_age++;
            if (ack_en && req_age == 10) fsm_req_ack = 1'b1;
         end
         if (fsm_done_ack) begin
            fsm_done = 1'b0; done_age = 0;
         end else if (fsm_req_ack && !fsm_done) begin
            done_age++;
            if (done_age == done_dly) fsm_done = 1'b1;
         end else if (!fsm_req_ack) begin
            done_age = 0;
         end
      end
   end

   // Event recorder, sampled 1 time unit after each rising edge
   bit   mon_clr = 1'b0;
   int   cyc = 0;
   int   n_load = 0, n_trig = 0, n_done = 0, n_req = 0;
   int   idx_q[$];
   int   width_q[$];
   int   delta_q[$];
   int   ack_cyc = 0, req_cyc = 0, tmo_cyc = 0, trig_w = 0;
   logic tmo_req = 1'b0;
   logic p_trig = 1'b0, p_ack = 1'b0, p_req = 1'b0, p_tmo = 1'b0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (mon_clr) begin
         n_load = 0; n_trig = 0; n_done = 0; n_req = 0;
         idx_q.delete(); width_q.delete(); delta_q.delete();
         tmo_cyc = 0; req_cyc = 0; tmo_req = 1'b0;
      end else begin
         if (pat_load) begin n_load++; idx_q.push_back(int'(pat_idx)); end
         if (frame_done) n_done++;
         if (fsm_req_ack && !p_ack) ack_cyc = cyc;
         if (fsm_req && !p_req) begin n_req++; req_cyc = cyc; end
         if (proj_trig && !p_trig) begin n_trig++; delta_q.push_back(cyc - ack_cyc); trig_w = 0; end
         if (proj_trig) trig_w++;
         if (!proj_trig && p_trig) width_q.push_back(trig_w);
         if (timeout_err && !p_tmo) begin tmo_cyc = cyc; tmo_req = fsm_req; end
      end
      p_trig = proj_trig; p_ack = fsm_req_ack; p_req = fsm_req; p_tmo = timeout_err;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic clear_mon();
      @(negedge clk); mon_clr = 1'b1;
      @(negedge clk); mon_clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin @(posedge clk); #2; k++; end
      chk({tag, " idle within budget"}, 64'(k < budget), 1);
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      int k;
      int exp_idx[5];
      exp_idx = '{0, 1, 0, 1, 0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset outputs", {pat_load, fsm_req, fsm_done_ack, proj_trig, busy, frame_done, timeout_err}, 0);
      chk("reset pat_idx", pat_idx, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle after reset release", busy, 0);

      // Three-subframe frame, plus a start/config change while busy that must be ignored
      num_pat = 3; exp_cycles = 20; trig_delay = 5; loop_en = 1'b0;
      clear_mon();
      pulse_start();
      chk("t1 busy after start", busy, 1);
      repeat (30) @(negedge clk);
      num_pat = 7; exp_cycles = 2;
      pulse_start();
      wait_idle(2000, "t1");
      repeat (3) @(negedge clk);
      chk("t1 pat_load count", n_load, 3);
      for (int i = 0; i < 3; i++) chk($sformatf("t1 pat_idx[%0d]", i), q_at(idx_q, i), i);
      chk("t1 trig count", n_trig, 3);
      // trigger rises 2 sync cycles + 5 delay cycles after the ack pin rises
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t1 trig width[%0d]", i), q_at(width_q, i), 4);
         chk($sformatf("t1 trig offset[%0d]", i), q_at(delta_q, i), 7);
      end
      chk("t1 frame_done count", n_done, 1);
      chk("t1 timeout_err", timeout_err, 0);

      // Short exposure truncates the trigger
      num_pat = 1; exp_cycles = 3; trig_delay = 1;
      clear_mon();
      pulse_start();
      wait_idle(500, "t2a");
      repeat (2) @(negedge clk);
      chk("t2a trig count", n_trig, 1);
      chk("t2a trig width", q_at(width_q, 0), 2);
      chk("t2a frame_done", n_done, 1);

      // Delay equal to exposure: no trigger, frame still completes
      trig_delay = 3;
      clear_mon();
      pulse_start();
      wait_idle(500, "t2b");
      repeat (2) @(negedge clk);
      chk("t2b trig count", n_trig, 0);
      chk("t2b frame_done", n_done, 1);

      // Imager never acks: timeout exactly 100 cycles after REQ entry
      ack_en = 1'b0; exp_cycles = 20; trig_delay = 5;
      clear_mon();
      pulse_start();
      k = 0;
      while (timeout_err !== 1'b1 && k < 500) begin @(posedge clk); #2; k++; end
      chk("t3 timeout seen", 64'(k < 500), 1);
      chk("t3 timeout latency", tmo_cyc - req_cyc, 100);
      chk("t3 fsm_req at timeout", tmo_req, 0);
      repeat (5) @(negedge clk);
      chk("t3 busy after timeout", busy, 0);
      chk("t3 no frame_done", n_done, 0);
      ack_en = 1'b1;
      pulse_start();
      chk("t3 start clears timeout_err", timeout_err, 0);
      wait_idle(500, "t3");
      repeat (2) @(negedge clk);
      chk("t3 recovery frame_done", n_done, 1);

      // Continuous mode, then abort during an exposure
      loop_en = 1'b1; num_pat = 2;
      clear_mon();
      pulse_start();
      k = 0;
      while (n_done < 2 && k < 2000) begin @(posedge clk); #2; k++; end
      chk("t4 two frames seen", 64'(k < 2000), 1);
      chk("t4 pat_idx wrapped", pat_idx, 0);
      chk("t4 pat_load count", n_load, 5);
      for (int i = 0; i < 5; i++) chk($sformatf("t4 pat_idx[%0d]", i), q_at(idx_q, i), exp_idx[i]);
      k = 0;
      while (!(proj_trig === 1'b1 && pat_idx == 8'd1) && k < 500) begin @(posedge clk); #2; k++; end
      chk("t4 reached exposure", 64'(k < 500), 1);
      @(negedge clk); abort = 1'b1;
      @(negedge clk);
      chk("t4 abort busy", busy, 0);
      chk("t4 abort outputs", {pat_load, fsm_req, fsm_done_ack, proj_trig, frame_done}, 0);
      chk("t4 abort pat_idx", pat_idx, 0);
      abort = 1'b0; loop_en = 1'b0;
      repeat (20) @(negedge clk);
      chk("t4 no frame_done after abort", n_done, 2);
      chk("t4 stays idle", busy, 0);

      // num_pat == 0: immediate frame_done, no handshake
      num_pat = 0;
      clear_mon();
      pulse_start();
      chk("t5 frame_done pulse", frame_done, 1);
      chk("t5 stays idle", busy, 0);
      @(negedge clk);
      chk("t5 frame_done one cycle", frame_done, 0);
      repeat (5) @(negedge clk);
      chk("t5 no fsm_req", n_req, 0);
      chk("t5 no pat_load", n_load, 0);

      // Asynchronous reset while waiting for done
      num_pat = 2; exp_cycles = 20; trig_delay = 5; done_dly = 60;
      clear_mon();
      pulse_start();
      k = 0;
      while (fsm_done !== 1'b1 && k < 500) begin @(posedge clk); #2; k++; end
      chk("t6 reached wait_done", 64'(k < 500), 1);
      chk("t6 fsm_req held", fsm_req, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6 async reset outputs", {pat_load, fsm_req, fsm_done_ack, proj_trig, busy, frame_done, timeout_err}, 0);
      chk("t6 async reset pat_idx", pat_idx, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; done_dly = 20;
      clear_mon();
      pulse_start();
      wait_idle(1000, "t6");
      repeat (2) @(negedge clk);
      chk("t6 frame_done", n_done, 1);
      chk("t6 pat_load count", n_load, 2);
      chk("t6 trig count", n_trig, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
